// File: rtl/gpu_pkg.sv
// Shared GPU datapath types and constants: pixel and SRAM word formats,
// plus the state encoding of the pixel-to-SRAM packer.
package gpu_pkg;

   localparam int PIX_W        = 24;
   localparam int PIX_PER_WORD = 64;
   localparam int SRAM_ADDR_W  = 19;
   localparam int SRAM_DATA_W  = PIX_W * PIX_PER_WORD;

   typedef logic [PIX_W-1:0]       pixel_t;
   typedef logic [SRAM_DATA_W-1:0] sram_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } packer_state_t;

endpackage

// File: rtl/flex_counter_wr.sv
// Up-counter with synchronous clear, count enable and a rollover flag that is
// high while the count sits at rollover_val; the next enabled step wraps to 0.
module flex_counter_wr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         clear,
   input  logic         count_enable,
   input  logic [W-1:0] rollover_val,
   output logic [W-1:0] count_out,
   output logic         rollover_flag
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (count_enable) begin
         r_count <= (r_count == rollover_val) ? '0 : r_count + W'(1);
      end
   end

   assign count_out     = r_count;
   assign rollover_flag = (r_count == rollover_val);

endmodule

// File: rtl/pixel_word_packer.sv
// Packs a 24-bit RGB pixel stream into wide SRAM words and issues each word as
// a WR_CYCLES-long write strobe at consecutive addresses from BASE_ADDR.
module pixel_word_packer
   import gpu_pkg::*;
#(
   parameter int                 PIX_W        = gpu_pkg::PIX_W,
   parameter int                 PIX_PER_WORD = gpu_pkg::PIX_PER_WORD,
   parameter int                 ADDR_W       = gpu_pkg::SRAM_ADDR_W,
   parameter logic [ADDR_W-1:0]  BASE_ADDR    = '0,
   parameter int                 FRAME_WORDS  = 4800,
   parameter int                 WR_CYCLES    = 2
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      start,
   input  logic                      pix_valid,
   input  logic [PIX_W-1:0]          pix_data,
   output logic                      pix_ready,
   input  logic                      flush,
   output logic                      read_enable,
   output logic                      write_enable,
   output logic [ADDR_W-1:0]         address,
   output logic [PIX_W*PIX_PER_WORD-1:0] write_data,
   output logic                      busy,
   output logic                      frame_done
);

   localparam int SLOT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
   localparam int STB_W  = $clog2(WR_CYCLES + 1);
   localparam int WORD_W = $clog2(FRAME_WORDS + 1);

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PIX_PER_WORD - 1);
   localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(WR_CYCLES - 1);
   localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(FRAME_WORDS - 1);

   packer_state_t                 r_state;
   packer_state_t                 w_next_state;
   logic [ADDR_W-1:0]             r_address;
   logic [PIX_W*PIX_PER_WORD-1:0] r_pack;

   logic              w_accept;
   logic              w_frame_start;
   logic              w_strobe_last;
   logic [SLOT_W-1:0] w_slot;
   logic              w_slot_flag;
   logic [STB_W-1:0]  w_stb_cnt;
   logic              w_stb_flag;
   logic [WORD_W-1:0] w_word_cnt;
   logic              w_word_flag;

   assign w_accept      = pix_valid && (r_state == FILL);
   assign w_frame_start = start && (r_state == IDLE);
   assign w_strobe_last = (r_state == WRITE) && w_stb_flag;

   flex_counter_wr #(.W(SLOT_W)) u_slot_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (w_frame_start || w_strobe_last),
      .count_enable  (w_accept),
      .rollover_val  (SLOT_LAST),
      .count_out     (w_slot),
      .rollover_flag (w_slot_flag)
   );

   flex_counter_wr #(.W(STB_W)) u_strobe_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (w_frame_start),
      .count_enable  (r_state == WRITE),
      .rollover_val  (STB_LAST),
      .count_out     (w_stb_cnt),
      .rollover_flag (w_stb_flag)
   );

   flex_counter_wr #(.W(WORD_W)) u_word_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (w_frame_start),
      .count_enable  (w_strobe_last),
      .rollover_val  (WORD_LAST),
      .count_out     (w_word_cnt),
      .rollover_flag (w_word_flag)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // A pixel arriving together with flush is counted before the flush test,
   // so a flush from an empty word still writes when it carries a pixel.
   always_comb begin
      w_next_state = r_state;
      pix_ready    = 1'b0;
      write_enable = 1'b0;
      busy         = 1'b1;
      frame_done   = 1'b0;
      unique case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start) w_next_state = FILL;
         end
         FILL: begin
            pix_ready = 1'b1;
            if ((w_accept && w_slot_flag) ||
                (flush && (w_accept || (w_slot != '0))))
               w_next_state = WRITE;
         end
         WRITE: begin
            write_enable = 1'b1;
            if (w_stb_flag) w_next_state = w_word_flag ? DONE : FILL;
         end
         DONE: begin
            frame_done   = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_address <= BASE_ADDR;
      end else if (w_frame_start || (r_state == DONE)) begin
         r_address <= BASE_ADDR;
      end else if (w_strobe_last && !w_word_flag) begin
         r_address <= r_address + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_pack <= '0;
      end else if (w_strobe_last) begin
         r_pack <= '0;
      end else if (w_accept) begin
         r_pack[int'(w_slot)*PIX_W +: PIX_W] <= pix_data;
      end
   end

   assign read_enable = 1'b0;
   assign address     = r_address;
   assign write_data  = r_pack;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed bench for pixel_word_packer, run with a short frame so the whole
// frame including frame_done and address wrap fits in a brief simulation.
module tb_pixel_word_packer;

   localparam int PIX_W    = 24;
   localparam int PPW      = 64;
   localparam int ADDR_W   = 19;
   localparam int DATA_W   = PIX_W * PPW;
   localparam int FRAME_W  = 8;
   localparam int WR_CYC   = 2;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              start;
   logic              pix_valid;
   logic [PIX_W-1:0]  pix_data;
   logic              pix_ready;
   logic              flush;
   logic              read_enable;
   logic              write_enable;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] write_data;
   logic              busy;
   logic              frame_done;

   int n_vec = 0;
   int n_err = 0;

   logic [ADDR_W-1:0] wr_addrs[$];
   int                done_pulses;
   logic              prev_we = 1'b0;
   logic [ADDR_W-1:0] prev_addr;
   logic [DATA_W-1:0] prev_data;
   logic [PIX_W-1:0]  exp_pix [PPW];

   pixel_word_packer #(
      .PIX_W        (PIX_W),
      .PIX_PER_WORD (PPW),
      .ADDR_W       (ADDR_W),
      .BASE_ADDR    ('0),
      .FRAME_WORDS  (FRAME_W),
      .WR_CYCLES    (WR_CYC)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .start        (start),
      .pix_valid    (pix_valid),
      .pix_data     (pix_data),
      .pix_ready    (pix_ready),
      .flush        (flush),
      .read_enable  (read_enable),
      .write_enable (write_enable),
      .address      (address),
      .write_data   (write_data),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_slot(input int k, input logic [PIX_W-1:0] exp);
      chk($sformatf("slot%0d", k), 64'(write_data[k*PIX_W +: PIX_W]), 64'(exp));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_we"},    64'(write_enable), 64'd0);
      chk({tag, "_re"},    64'(read_enable),  64'd0);
      chk({tag, "_addr"},  64'(address),      64'd0);
      chk({tag, "_wdata"}, 64'(write_data == '0), 64'd1);
      chk({tag, "_busy"},  64'(busy),         64'd0);
      chk({tag, "_done"},  64'(frame_done),   64'd0);
      chk({tag, "_rdy"},   64'(pix_ready),    64'd0);
   endtask

   // Every cycle: no reads, and the word/address hold still across the strobe.
   always @(negedge clk) begin
      chk("read_enable", 64'(read_enable), 64'd0);
      if (write_enable && prev_we) begin
         chk("addr_stable",  64'(address), 64'(prev_addr));
         chk("wdata_stable", 64'(write_data == prev_data), 64'd1);
      end
      if (write_enable && !prev_we) wr_addrs.push_back(address);
      if (frame_done) done_pulses++;
      prev_we   <= write_enable;
      prev_addr <= address;
      prev_data <= write_data;
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic push(input logic [PIX_W-1:0] d, input int gap);
      int t;
      repeat (gap) @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = d;
      t = 0;
      while (!pix_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
      pix_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("rst");
      n_rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      n_rst = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0; flush = 1'b0;
      done_pulses = 0;
      @(negedge clk);
      do_reset();

      // word 0: 64 pixels with value k
      pulse_start();
      chk("start_busy", 64'(busy), 64'd1);
      chk("start_rdy",  64'(pix_ready), 64'd1);
      for (int k = 0; k < PPW; k++) push(PIX_W'(k), 0);
      chk("w0_we_lat", 64'(write_enable), 64'd1);
      chk("w0_rdy",    64'(pix_ready), 64'd0);
      chk("w0_addr",   64'(address), 64'd0);
      for (int k = 0; k < PPW; k++) chk_slot(k, PIX_W'(k));
      @(negedge clk);
      chk("w0_we_c2",  64'(write_enable), 64'd1);
      chk("w0_rdy_c2", 64'(pix_ready), 64'd0);
      @(negedge clk);
      chk("w0_we_off", 64'(write_enable), 64'd0);
      chk("w0_cleared", 64'(write_data == '0), 64'd1);
      chk("w1_addr", 64'(address), 64'd1);

      // word 1: 10 white pixels, then flush
      for (int k = 0; k < 10; k++) push(24'hFFFFFF, 0);
      do_flush();
      chk("fl_we",   64'(write_enable), 64'd1);
      chk("fl_addr", 64'(address), 64'd1);
      chk("fl_ones", 64'(write_data[239:0] == {240{1'b1}}), 64'd1);
      chk("fl_zero", 64'(write_data[DATA_W-1:240] == '0), 64'd1);
      repeat (2) @(negedge clk);

      // word 2: pixel and flush together from an empty word land in slot 0
      pix_valid = 1'b1; pix_data = 24'hABCDEF; flush = 1'b1;
      @(negedge clk);
      pix_valid = 1'b0; flush = 1'b0;
      chk("pf_we",   64'(write_enable), 64'd1);
      chk("pf_addr", 64'(address), 64'd2);
      chk_slot(0, 24'hABCDEF);
      chk("pf_rest", 64'(write_data[DATA_W-1:PIX_W] == '0), 64'd1);
      repeat (2) @(negedge clk);

      // flush at slot 0 is ignored; start in FILL is ignored
      do_flush();
      chk("fl0_we",  64'(write_enable), 64'd0);
      @(negedge clk);
      chk("fl0_we2", 64'(write_enable), 64'd0);
      chk("fl0_rdy", 64'(pix_ready), 64'd1);
      for (int k = 1; k <= 3; k++) push(PIX_W'(k), 0);
      pulse_start();
      chk("stF_addr", 64'(address), 64'd3);
      push(24'd4, 0);
      do_flush();
      chk("stF_we",   64'(write_enable), 64'd1);
      chk("stF_addr2", 64'(address), 64'd3);
      chk_slot(0, 24'd1);
      chk_slot(3, 24'd4);
      // start during the strobe
      pulse_start();
      chk("stW_we",   64'(write_enable), 64'd1);
      chk("stW_addr", 64'(address), 64'd3);
      @(negedge clk);
      chk("stW_off",  64'(write_enable), 64'd0);
      chk("stW_next", 64'(address), 64'd4);

      // word 4 then word 5, reset during the first strobe cycle of word 5
      push(24'd7, 0);
      do_flush();
      chk_slot(0, 24'd7);
      repeat (2) @(negedge clk);
      push(24'd9, 0);
      do_flush();
      chk("w5_we",   64'(write_enable), 64'd1);
      chk("w5_addr", 64'(address), 64'd5);
      #1 n_rst = 1'b0;
      #1 chk_reset_outputs("midrst");
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      wr_addrs.delete();
      pulse_start();
      push(24'h123456, 0);
      do_flush();
      chk("postrst_addr", 64'(address), 64'd0);
      chk_slot(0, 24'h123456);
      chk("postrst_prev", 64'(write_data[DATA_W-1:PIX_W] == '0), 64'd1);

      // full short frame with random pixels and gaps
      do_reset();
      wr_addrs.delete();
      done_pulses = 0;
      pulse_start();
      for (int w = 0; w < FRAME_W; w++) begin
         for (int k = 0; k < PPW; k++) begin
            exp_pix[k] = PIX_W'($urandom);
            push(exp_pix[k], $urandom_range(0, 2));
         end
         chk($sformatf("fr%0d_we", w),   64'(write_enable), 64'd1);
         chk($sformatf("fr%0d_addr", w), 64'(address), 64'(w));
         for (int k = 0; k < PPW; k++) chk_slot(k, exp_pix[k]);
         repeat (2) @(negedge clk);
      end
      chk("fr_done",     64'(frame_done), 64'd1);
      chk("fr_done_we",  64'(write_enable), 64'd0);
      @(negedge clk);
      chk("fr_done_off", 64'(frame_done), 64'd0);
      chk("fr_idle",     64'(busy), 64'd0);
      chk("fr_wrap",     64'(address), 64'd0);
      chk("fr_pulses",   64'(done_pulses), 64'd1);
      chk("fr_nwrites",  64'(wr_addrs.size()), 64'(FRAME_W));
      for (int i = 0; i < wr_addrs.size(); i++)
         chk($sformatf("fr_order%0d", i), 64'(wr_addrs[i]), 64'(i));
      repeat (3) @(negedge clk);
      chk("fr_stay_idle", 64'(busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
